// File: rtl/inst_generator.sv
// inst_generator: seeded pseudo-random RV32IM instruction-stream generator.
// Every emitted word is drawn from a restricted legal set (I-ALU, x0-based
// loads/stores with negative offsets, R-type/M-ext, LUI, NOP) and is handed
// out over a valid/ready handshake.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_i         begin a run (honoured only in IDLE)
//   seed_i          LFSR seed, 0 selects SEED
//   num_insn_i      number of instructions in the run
//   insn_valid_o    insn_o/insn_class_o hold a valid instruction
//   insn_ready_i    consumer accepts the current instruction
//   insn_o          instruction word
//   insn_class_o    generator class of insn_o (LFSR bits [2:0])
//   busy_o          generator not idle
//   done_o          one-cycle pulse at end of run
//   count_o         instructions accepted in the current or last run
module inst_generator #(
    parameter logic [31:0] SEED  = 32'hACE1_2468,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [31:0]      seed_i,
    input  logic [CNT_W-1:0] num_insn_i,
    output logic             insn_valid_o,
    input  logic             insn_ready_i,
    output logic [31:0]      insn_o,
    output logic [2:0]       insn_class_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [31:0] NOP_INSN  = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, PREP, EMIT, DONE} state_t;

    state_t           state_q, state_nxt;
    logic [31:0]      lfsr_q, lfsr_nxt;
    logic [CNT_W-1:0] n_q, n_nxt;
    logic [CNT_W-1:0] count_q, count_nxt;
    logic [31:0]      insn_q, insn_nxt;
    logic [2:0]       class_q, class_nxt;
    logic             valid_q, valid_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;

    // Galois LFSR step, shift right
    function automatic logic [31:0] lfsr_step(input logic [31:0] r);
        logic [31:0] s;
        s = {1'b0, r[31:1]};
        if (r[0]) s = s ^ LFSR_MASK;
        return s;
    endfunction

    // Map an LFSR value onto a legal instruction word
    function automatic logic [31:0] enc(input logic [31:0] r);
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3, f3s;
        logic [11:0] imm12;
        logic [6:0]  f7;
        logic [31:0] w;
        rd    = (r[6:3] == 4'd0) ? 5'd1 : {1'b0, r[6:3]};
        rs1   = {1'b0, r[10:7]};
        rs2   = {1'b0, r[14:11]};
        f3    = r[17:15];
        imm12 = r[29:18];
        f3s   = {1'b0, r[16:15]};
        f7    = 7'b0000000;
        w     = NOP_INSN;
        case (r[2:0])
            3'd0, 3'd1: begin
                if (f3 == 3'b001)
                    w = {7'b0000000, imm12[4:0], rs1, f3, rd, 7'b0010011};
                else if (f3 == 3'b101)
                    w = {(r[31] ? 7'b0100000 : 7'b0000000), imm12[4:0], rs1, f3, rd, 7'b0010011};
                else
                    w = {imm12, rs1, f3, rd, 7'b0010011};
            end
            3'd2: begin
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) f3 = 3'b010;
                w = {1'b1, imm12[10:0], 5'd0, f3, rd, 7'b0000011};
            end
            3'd3, 3'd4: begin
                if (r[30])
                    f7 = 7'b0000001;
                else if ((f3 == 3'b000 || f3 == 3'b101) && r[31])
                    f7 = 7'b0100000;
                w = {f7, rs2, rs1, f3, rd, 7'b0110011};
            end
            3'd5: begin
                if (f3s == 3'b011) f3s = 3'b010;
                w = {1'b1, r[29:24], rs2, 5'd0, f3s, r[23:19], 7'b0100011};
            end
            3'd6:    w = {r[31:12], rd, 7'b0110111};
            default: w = NOP_INSN;
        endcase
        return w;
    endfunction

    // Next-state and registered-output values
    always_comb begin
        state_nxt = state_q;
        lfsr_nxt  = lfsr_q;
        n_nxt     = n_q;
        count_nxt = count_q;
        insn_nxt  = insn_q;
        class_nxt = class_q;
        valid_nxt = valid_q;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    n_nxt     = num_insn_i;
                    lfsr_nxt  = (seed_i == 32'd0) ? SEED : seed_i;
                    count_nxt = '0;
                    state_nxt = (num_insn_i != '0) ? PREP : DONE;
                end
            end
            PREP: begin
                insn_nxt  = enc(lfsr_q);
                class_nxt = lfsr_q[2:0];
                valid_nxt = 1'b1;
                lfsr_nxt  = lfsr_step(lfsr_q);
                state_nxt = EMIT;
            end
            EMIT: begin
                if (valid_q && insn_ready_i) begin
                    count_nxt = count_q + CNT_W'(1);
                    if (count_q + CNT_W'(1) == n_q) begin
                        valid_nxt = 1'b0;
                        state_nxt = DONE;
                    end else begin
                        insn_nxt  = enc(lfsr_q);
                        class_nxt = lfsr_q[2:0];
                        lfsr_nxt  = lfsr_step(lfsr_q);
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            n_q     <= '0;
            count_q <= '0;
            insn_q  <= NOP_INSN;
            class_q <= 3'd7;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            lfsr_q  <= lfsr_nxt;
            n_q     <= n_nxt;
            count_q <= count_nxt;
            insn_q  <= insn_nxt;
            class_q <= class_nxt;
            valid_q <= valid_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
        end
    end

    assign insn_valid_o = valid_q;
    assign insn_o       = insn_q;
    assign insn_class_o = class_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign count_o      = count_q;

endmodule

// File: tb/tb_inst_generator.sv
// Testbench for inst_generator: randomized runs checked against a
// behavioural model of the LFSR and encoder plus an independent legality check.
module tb_inst_generator;

    localparam logic [31:0] SEED = 32'hACE1_2468;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [31:0]      seed;
    logic [CNT_W-1:0] num;
    logic             insn_valid;
    logic             insn_ready;
    logic [31:0]      insn;
    logic [2:0]       insn_class;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] got_w[$];
    logic [2:0]  got_c[$];
    logic [31:0] exp_w[$];
    logic [2:0]  exp_c[$];
    int st_dones, st_viol, st_span, st_extra_valid;
    bit st_timeout;

    inst_generator #(.SEED(SEED), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start_i(start), .seed_i(seed), .num_insn_i(num),
        .insn_valid_o(insn_valid), .insn_ready_i(insn_ready), .insn_o(insn),
        .insn_class_o(insn_class), .busy_o(busy), .done_o(done), .count_o(count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_next(input logic [31:0] r);
        logic [31:0] s;
        s = r / 2;
        if (r % 2 == 1) s = s ^ 32'h8020_0003;
        return s;
    endfunction

    function automatic logic [31:0] m_enc(input logic [31:0] r);
        logic [31:0] cls, rd, rs1, rs2, f3, imm, top, b30, f7, imm7, imm5;
        cls = r & 7;
        rd  = (r >> 3) & 15;
        if (rd == 0) rd = 1;
        rs1 = (r >> 7) & 15;
        rs2 = (r >> 11) & 15;
        f3  = (r >> 15) & 7;
        imm = (r >> 18) & 32'hFFF;
        top = r >> 31;
        b30 = (r >> 30) & 1;
        case (cls)
            0, 1: begin
                if (f3 == 1) imm = imm & 31;
                else if (f3 == 5) imm = (imm & 31) + (top != 0 ? 32'h400 : 32'h0);
                return (imm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
            end
            2: begin
                imm = imm | 32'h800;
                if (f3 == 3 || f3 == 6 || f3 == 7) f3 = 2;
                return (imm << 20) | (f3 << 12) | (rd << 7) | 32'h03;
            end
            3, 4: begin
                if (b30 != 0) f7 = 1;
                else if ((f3 == 0 || f3 == 5) && top != 0) f7 = 32;
                else f7 = 0;
                return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
            end
            5: begin
                f3 = (r >> 15) & 3;
                if (f3 == 3) f3 = 2;
                imm7 = 64 + ((r >> 24) & 63);
                imm5 = (r >> 19) & 31;
                return (imm7 << 25) | (rs2 << 20) | (f3 << 12) | (imm5 << 7) | 32'h23;
            end
            6: return (r & 32'hFFFF_F000) | (rd << 7) | 32'h37;
            default: return 32'h13;
        endcase
    endfunction

    // Expected stream for a run
    task automatic model_run(input logic [31:0] s, input int n);
        logic [31:0] r;
        r = (s == 0) ? SEED : s;
        exp_w.delete();
        exp_c.delete();
        for (int i = 0; i < n; i++) begin
            exp_w.push_back(m_enc(r));
            exp_c.push_back(3'(r & 7));
            r = m_next(r);
        end
    endtask

    // Independent legality rules for the fuzzing constraint set
    function automatic bit legal(input logic [31:0] w);
        logic [6:0] op, f7;
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        op = w[6:0]; rd = w[11:7]; f3 = w[14:12]; rs1 = w[19:15]; rs2 = w[24:20]; f7 = w[31:25];
        if (w == 32'h13) return 1'b1;
        case (op)
            7'b0010011: begin
                if (rd < 1 || rd > 15 || rs1 > 15) return 1'b0;
                if (f3 == 3'b001 && f7 != 0) return 1'b0;
                if (f3 == 3'b101 && f7 != 0 && f7 != 7'h20) return 1'b0;
                return 1'b1;
            end
            7'b0000011:
                return rs1 == 0 && w[31] && rd >= 1 && rd <= 15 &&
                       (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
            7'b0100011:
                return rs1 == 0 && w[31] && rs2 <= 15 && f3 <= 2;
            7'b0110011: begin
                if (rd < 1 || rd > 15 || rs1 > 15 || rs2 > 15) return 1'b0;
                if (f7 == 7'h20) return f3 == 0 || f3 == 5;
                return f7 == 0 || f7 == 1;
            end
            7'b0110111: return rd >= 1 && rd <= 15;
            default:    return 1'b0;
        endcase
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic start_run(input logic [31:0] s, input int n);
        start = 1'b1;
        seed  = s;
        num   = CNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Consume a run, recording accepted words, done pulses and stall stability
    task automatic run_stream(input int n, input int ready_pct);
        int cyc;
        int first;
        int last;
        bit pv, pr;
        logic [31:0] pw;
        logic [2:0]  pc;
        cyc = 0; first = -1; last = -1; pv = 0; pr = 0; pw = '0; pc = '0;
        got_w.delete(); got_c.delete();
        st_dones = 0; st_viol = 0; st_timeout = 0; st_extra_valid = 0;
        while (cyc < n * 20 + 50) begin
            if (done === 1'b1) st_dones++;
            if (got_w.size() == n && st_dones > 0) break;
            if (pv && !pr && !(insn_valid === 1'b1 && insn === pw && insn_class === pc)) st_viol++;
            insn_ready = ($urandom_range(99) < ready_pct);
            if (insn_valid === 1'b1 && insn_ready) begin
                got_w.push_back(insn);
                got_c.push_back(insn_class);
                if (first < 0) first = cyc;
                last = cyc;
            end
            pv = (insn_valid === 1'b1); pr = insn_ready; pw = insn; pc = insn_class;
            @(posedge clk); #1;
            cyc++;
        end
        if (!(got_w.size() == n && st_dones > 0)) st_timeout = 1;
        insn_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done === 1'b1) st_dones++;
            if (insn_valid === 1'b1) st_extra_valid++;
        end
        st_span = last - first + 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; seed = '0; num = '0; insn_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (insn_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b expected 0", insn_valid); end
        n_checks++; if (insn !== 32'h13) begin n_fail++; $display("FAIL reset_insn got %h expected 00000013", insn); end
        n_checks++; if (insn_class !== 3'd7) begin n_fail++; $display("FAIL reset_class got %0d expected 7", insn_class); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done got %b%b expected 00", busy, done); end
        n_checks++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got %0d expected 0", count); end
        rst = 1'b0;
    endtask

    task automatic test_first_insn();
        insn_ready = 1'b1;
        model_run(32'd1, 1);
        start_run(32'd1, 1);
        n_checks++; if (insn_valid !== 1'b0) begin n_fail++; $display("FAIL first_prep_valid got %b expected 0", insn_valid); end
        @(posedge clk); #1;
        n_checks++; if (insn_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid got %b expected 1", insn_valid); end
        n_checks++; if (insn !== 32'h0000_0093 || insn !== exp_w[0]) begin n_fail++; $display("FAIL first_insn got %h expected 00000093 (model %h)", insn, exp_w[0]); end
        n_checks++; if (insn_class !== 3'd1) begin n_fail++; $display("FAIL first_class got %0d expected 1", insn_class); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b1 || insn_valid !== 1'b0) begin n_fail++; $display("FAIL first_done got done=%b valid=%b expected done=1 valid=0", done, insn_valid); end
        n_checks++; if (count !== CNT_W'(1)) begin n_fail++; $display("FAIL first_count got %0d expected 1", count); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL first_idle got done=%b busy=%b expected 0 0", done, busy); end
        insn_ready = 1'b0;
    endtask

    task automatic test_seed_zero();
        logic [31:0] first_run[$];
        model_run(SEED, 3);
        start_run(32'd0, 3);
        run_stream(3, 100);
        first_run = got_w;
        n_checks++; if (st_timeout) begin n_fail++; $display("FAIL seed0_timeout got %0d words expected 3", got_w.size()); end
        for (int i = 0; i < got_w.size() && i < 3; i++) begin
            n_checks++; if (got_w[i] !== exp_w[i]) begin n_fail++; $display("FAIL seed0_word[%0d] got %h expected %h", i, got_w[i], exp_w[i]); end
        end
        start_run(SEED, 3);
        run_stream(3, 100);
        n_checks++; if (got_w.size() != first_run.size()) begin n_fail++; $display("FAIL seed0_len got %0d expected %0d", got_w.size(), first_run.size()); end
        for (int i = 0; i < got_w.size() && i < first_run.size(); i++) begin
            n_checks++; if (got_w[i] !== first_run[i]) begin n_fail++; $display("FAIL seed0_replay[%0d] got %h expected %h", i, got_w[i], first_run[i]); end
        end
    endtask

    task automatic test_random_stall();
        logic [31:0] s;
        int illegal;
        s = $urandom();
        model_run(s, 1000);
        start_run(s, 1000);
        run_stream(1000, 50);
        n_checks++; if (st_timeout) begin n_fail++; $display("FAIL stall_timeout got %0d words expected 1000", got_w.size()); end
        n_checks++; if (st_viol != 0) begin n_fail++; $display("FAIL stall_stability got %0d changes expected 0", st_viol); end
        n_checks++; if (st_dones != 1) begin n_fail++; $display("FAIL stall_dones got %0d expected 1", st_dones); end
        n_checks++; if (count !== CNT_W'(1000)) begin n_fail++; $display("FAIL stall_count got %0d expected 1000", count); end
        illegal = 0;
        for (int i = 0; i < got_w.size() && i < 1000; i++) begin
            if (!legal(got_w[i])) illegal++;
            n_checks++;
            if (got_w[i] !== exp_w[i] || got_c[i] !== exp_c[i]) begin
                n_fail++;
                $display("FAIL stall_word[%0d] got %h/%0d expected %h/%0d", i, got_w[i], got_c[i], exp_w[i], exp_c[i]);
            end
        end
        n_checks++; if (illegal != 0) begin n_fail++; $display("FAIL stall_legality got %0d illegal words expected 0", illegal); end
    endtask

    task automatic test_n_zero();
        bit saw_valid;
        start_run($urandom(), 0);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL nzero_done got %b expected 1", done); end
        saw_valid = (insn_valid === 1'b1);
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL nzero_idle got done=%b busy=%b expected 0 0", done, busy); end
        n_checks++; if (count !== '0) begin n_fail++; $display("FAIL nzero_count got %0d expected 0", count); end
        repeat (3) begin @(posedge clk); #1; if (insn_valid === 1'b1) saw_valid = 1; end
        n_checks++; if (saw_valid) begin n_fail++; $display("FAIL nzero_valid got 1 expected 0"); end
    endtask

    task automatic test_start_ignored();
        logic [31:0] s;
        s = $urandom();
        model_run(s, 5);
        insn_ready = 1'b0;
        start_run(s, 5);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; seed = 32'h1234_5678; num = CNT_W'(2);
        @(posedge clk); #1;
        start = 1'b0;
        run_stream(5, 100);
        n_checks++; if (st_timeout || got_w.size() != 5) begin n_fail++; $display("FAIL ignore_len got %0d expected 5", got_w.size()); end
        n_checks++; if (count !== CNT_W'(5)) begin n_fail++; $display("FAIL ignore_count got %0d expected 5", count); end
        for (int i = 0; i < got_w.size() && i < 5; i++) begin
            n_checks++; if (got_w[i] !== exp_w[i]) begin n_fail++; $display("FAIL ignore_word[%0d] got %h expected %h", i, got_w[i], exp_w[i]); end
        end
    endtask

    task automatic test_reset_midrun();
        bit bad;
        insn_ready = 1'b1;
        start_run($urandom(), 10);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (insn_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b expected 0", insn_valid); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_state got busy=%b done=%b expected 0 0", busy, done); end
        n_checks++; if (count !== '0 || insn !== 32'h13) begin n_fail++; $display("FAIL midrst_regs got count=%0d insn=%h expected 0 00000013", count, insn); end
        bad = 0;
        repeat (4) begin @(posedge clk); #1; if (done === 1'b1 || insn_valid === 1'b1 || busy === 1'b1) bad = 1; end
        n_checks++; if (bad) begin n_fail++; $display("FAIL midrst_quiet got activity expected idle"); end
        insn_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] s;
        s = $urandom();
        model_run(s, 8);
        start_run(s, 8);
        run_stream(8, 100);
        n_checks++; if (st_timeout) begin n_fail++; $display("FAIL b2b_timeout got %0d words expected 8", got_w.size()); end
        n_checks++; if (st_span != 8) begin n_fail++; $display("FAIL b2b_span got %0d cycles expected 8", st_span); end
        n_checks++; if (st_dones != 1 || st_extra_valid != 0) begin n_fail++; $display("FAIL b2b_end got dones=%0d extra=%0d expected 1 0", st_dones, st_extra_valid); end
        n_checks++; if (count !== CNT_W'(8)) begin n_fail++; $display("FAIL b2b_count got %0d expected 8", count); end
        for (int i = 0; i < got_w.size() && i < 8; i++) begin
            n_checks++; if (got_w[i] !== exp_w[i]) begin n_fail++; $display("FAIL b2b_word[%0d] got %h expected %h", i, got_w[i], exp_w[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_first_insn();
        test_seed_zero();
        test_random_stall();
        test_n_zero();
        test_start_ignored();
        test_reset_midrun();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_generator.md
Name: inst_generator

Overview:
- Sequential instruction-stream generator for the biriscv fuzzing harness, the producing side of the instruction-legality constraint checker.
- Emits a seeded pseudo-random sequence of 32-bit RV32IM instructions. Every instruction lies inside the legal set:
  - I-type ALU ops
  - loads and stores with rs1=x0 and a negative offset
  - R-type ALU and M-extension ops
  - LUI
  - canonical NOP
- Feeds the core's fetch stimulus through a valid/ready handshake. Each instruction is generated once per accepted transfer, so replay is deterministic from the seed.

Parameters:
- SEED, 32'hACE1_2468, default LFSR seed; also substituted whenever seed_i is 0.
- CNT_W, 16, width of the instruction counter and of num_insn_i.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- start_i  input  1  begin a run; honoured only in IDLE
- seed_i  input  32  LFSR seed, latched on an accepted start
- num_insn_i  input  CNT_W  instructions to emit, latched on an accepted start
- insn_valid_o  output  1  insn_o holds a valid instruction
- insn_ready_i  input  1  consumer accepts
- insn_o  output  32  instruction word
- insn_class_o  output  3  class code of insn_o, equal to r[2:0] before remap
- busy_o  output  1  high in any state other than IDLE
- done_o  output  1  one-cycle pulse at end of run
- count_o  output  CNT_W  instructions accepted in the current or last run

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE
  - insn_valid_o=0
  - insn_o=32'h0000_0013
  - insn_class_o=7
  - busy_o=0
  - done_o=0
  - count_o=0
  - lfsr=SEED
- A reset asserted mid-run aborts the run: insn_valid_o is 0 from the next edge, and no done_o pulse is produced.
- LFSR: 32-bit Galois, shift right, XOR mask 32'h8020_0003 applied when the shifted-out bit is 1. r denotes the current LFSR value.
- FSM states and transitions:
  - IDLE, start_i=1:
    - latch N=num_insn_i
    - lfsr <= (seed_i==0 ? SEED : seed_i)
    - count_o <= 0
    - go to PREP if N!=0, else DONE
    - start_i in any other state is ignored.
  - PREP (one cycle):
    - insn_o <= enc(r), insn_class_o <= r[2:0]
    - insn_valid_o <= 1
    - lfsr <= next(r)
    - go to EMIT
    - First valid is 2 cycles after the start edge.
  - EMIT while valid and not ready: insn_o, insn_class_o and insn_valid_o are held stable and the LFSR is frozen.
  - EMIT on valid&&ready:
    - count_o++
    - if count_o+1==N: insn_valid_o <= 0, go to DONE
    - else: load enc(r) and advance the LFSR in the same cycle, giving back-to-back throughput of 1 per cycle.
  - DONE: done_o=1 for exactly this cycle, then go to IDLE. count_o holds its value until the next start.
- enc(r), common field rules:
  - rd = r[6:3], zero-extended; rd==0 is replaced by 1
  - rs1 = {0,r[10:7]}
  - rs2 = {0,r[14:11]}
  - f3 = r[17:15]
  - imm12 = r[29:18]
- enc(r), per class r[2:0]:
  - 0,1 I-ALU (opcode 0010011):
    - f3=001 (SLLI): funct7=0, shamt=imm12[4:0]
    - f3=101: funct7 = r[31] ? 0100000 : 0000000 (SRAI or SRLI)
    - all other f3: imm12 is used as is
  - 2 LOAD (opcode 0000011):
    - rs1=0, imm12[11] forced to 1
    - f3 in {011,110,111} is remapped to 010
  - 3,4 R-type (opcode 0110011):
    - funct7 = r[30] ? 0000001 : ((f3==000 || f3==101) && r[31] ? 0100000 : 0000000)
  - 5 STORE (opcode 0100011):
    - f3={0,r[16:15]}, with 011 remapped to 010
    - rs1=0, imm7 = {1'b1, r[29:24]}, imm5 = r[23:19]
    - rd field not used
  - 6 LUI (opcode 0110111): imm20 = r[31:12]
  - 7 NOP: 32'h0000_0013
- count_o is CNT_W bits. N=2^CNT_W-1 is supported, with no wrap inside a run.
- No JAL, JALR, AUIPC or branch is ever produced. No register above x15 is ever produced.

Test Plan:
- Reset, then start_i with seed_i=1, N=1, ready=1:
  - valid rises 2 cycles after start with insn_o=32'h0000_0093 (addi x1,x0,0) and insn_class_o=1
  - done_o pulses the cycle after acceptance; count_o=1
- seed_i=0, N=3: run equals a run with seed_i=SEED, identical word sequence.
- N=1000, ready randomly toggled: insn_o/class stable while stalled. Every word passes the legality checker:
  - rd in 1..15; rs in 0..15
  - load/store rs1=0 with negative offset
  - shift funct7 legal
  - count_o=1000 with exactly one done_o.
- N=0: done_o pulses 1 cycle after start; insn_valid_o never rises; count_o=0.
- start_i pulsed during EMIT: ignored, N unchanged. rst asserted mid-run: valid=0 next cycle, state IDLE, no done_o.
- Ready held high, N=8: 8 transfers on 8 consecutive cycles, no bubbles.
